// File: rtl/alu_commit.sv
// alu_commit: execute-to-writeback stage behind the ALU.
// Owns the architectural flags register, buffers ALU results in a small
// in-order FIFO for register writeback, supports a one-cycle flush and
// counts accepted ops.
module alu_commit #(
  parameter int DEPTH  = 2,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_result,
  input  logic [6:0]        in_status,
  input  logic              in_no_wr,
  input  logic [DEST_W-1:0] in_dest,
  input  logic [1:0]        in_df_op,
  input  logic              flush,
  output logic [6:0]        status_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wr_en,
  output logic [31:0]       retired
);

  // Status word bit order shared with the ALU.
  localparam int STAT_CF = 0;
  localparam int STAT_PF = 1;
  localparam int STAT_AF = 2;
  localparam int STAT_ZF = 3;
  localparam int STAT_SF = 4;
  localparam int STAT_DF = 5;
  localparam int STAT_OF = 6;

  // Flags copied straight from the ALU on accept; DF is owned by this stage.
  localparam logic [6:0] ARITH_MASK = 7'((1 << STAT_CF) | (1 << STAT_PF) | (1 << STAT_AF) |
                                         (1 << STAT_ZF) | (1 << STAT_SF) | (1 << STAT_OF));

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    DF_KEEP  = 2'b00,
    DF_CLEAR = 2'b01,
    DF_SET   = 2'b10,
    DF_KEEP2 = 2'b11
  } df_op_e;

  typedef struct packed {
    logic [31:0]       result;
    logic [DEST_W-1:0] dest;
    logic              wr_en;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [6:0]        flags_q;
  logic [31:0]       retired_q;
  logic              empty;
  logic              full;
  logic              accept;
  logic              pop;
  logic              next_df;
  entry_t            head;

  // Occupancy state: the extra pointer MSB separates full from empty.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // in_ready depends only on registered pointers, so a full FIFO never
  // accepts in the same cycle it pops.
  assign in_ready = !full;
  assign accept   = in_valid && !full && !flush;
  assign pop      = !empty && out_ready && !flush;

  // Direction flag update selected by the df op; unknown encoding keeps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    next_df = flags_q[STAT_DF];
    case (df_op_e'(in_df_op))
      DF_CLEAR: next_df = 1'b0;
      DF_SET:   next_df = 1'b1;
      default:  next_df = flags_q[STAT_DF];
    endcase
  end

  // Pointers, flags and retired counter; flush only touches the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else if (flush) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept) begin
        wr_ptr             <= wr_ptr + 1'b1;
        retired_q          <= retired_q + 32'd1;
        flags_q            <= (in_status & ARITH_MASK) | (flags_q & ~ARITH_MASK);
        flags_q[STAT_DF]   <= next_df;
      end
    end
  end

  // Entry storage written at the tail on accept.
  // NOTE: the storage array has no reset; stale contents are never visible
  // because the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr[AW-1:0]] <= '{result: in_result, dest: in_dest, wr_en: !in_no_wr};
    end
  end

  // Head entry drives writeback; only registered state feeds these outputs.
  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_valid  = !empty;
  assign out_result = empty ? '0   : head.result;
  assign out_dest   = empty ? '0   : head.dest;
  assign out_wr_en  = empty ? 1'b0 : head.wr_en;
  assign status_q   = flags_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_alu_commit.sv
// Self-checking bench for alu_commit: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_alu_commit;

  localparam int DEPTH  = 2;
  localparam int DEST_W = 3;
  localparam int DF     = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_result;
  logic [6:0]        in_status;
  logic              in_no_wr;
  logic [DEST_W-1:0] in_dest;
  logic [1:0]        in_df_op;
  logic              flush;
  logic [6:0]        status_q;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [DEST_W-1:0] out_dest;
  logic              out_wr_en;
  logic [31:0]       retired;

  alu_commit #(.DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_status(in_status), .in_no_wr(in_no_wr), .in_dest(in_dest),
    .in_df_op(in_df_op), .flush(flush), .status_q(status_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_wr_en(out_wr_en), .retired(retired)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of pending writebacks plus flag/count state.
  typedef struct {
    logic [31:0]       result;
    logic [DEST_W-1:0] dest;
    logic              wr;
  } op_t;

  op_t         model_q[$];
  logic [6:0]  m_flags;
  logic [31:0] m_retired;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_all(input string tag);
    op_t h;
    h = '{result: 32'h0, dest: '0, wr: 1'b0};
    if (model_q.size() > 0) h = model_q[0];
    check({tag, ".in_ready"},   32'(in_ready),   32'(model_q.size() < DEPTH));
    check({tag, ".out_valid"},  32'(out_valid),  32'(model_q.size() > 0));
    check({tag, ".out_result"}, out_result,      h.result);
    check({tag, ".out_dest"},   32'(out_dest),   32'(h.dest));
    check({tag, ".out_wr_en"},  32'(out_wr_en),  32'(h.wr));
    check({tag, ".status_q"},   32'(status_q),   32'(m_flags));
    check({tag, ".retired"},    retired,         m_retired);
  endtask

  // One clock: drive at the falling edge, update the model at the rising edge,
  // check at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [31:0] r,
                      input logic [6:0] st, input logic nw, input logic [DEST_W-1:0] d,
                      input logic [1:0] df, input logic fl, input logic ordy);
    bit acc, pp;
    in_valid = v; in_result = r; in_status = st; in_no_wr = nw;
    in_dest = d; in_df_op = df; flush = fl; out_ready = ordy;
    acc = v && (model_q.size() < DEPTH) && !fl;
    pp  = (model_q.size() > 0) && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (pp) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back('{result: r, dest: d, wr: !nw});
        m_retired = m_retired + 1;
        m_flags[6:0] = {st[6], (df == 2'b10) ? 1'b1 : (df == 2'b01) ? 1'b0 : m_flags[DF], st[4:0]};
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, 32'h0, 7'h0, 1'b0, '0, 2'b00, 1'b0, ordy);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; in_result = 0; in_status = 0; in_no_wr = 0;
    in_dest = 0; in_df_op = 0; flush = 0; out_ready = 0;
    m_flags = 7'h00; m_retired = 32'h0;

    // 1. Reset held for two cycles, then released.
    repeat (2) @(negedge clk);
    check_all("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset_released");

    // 2. Single accept with ZF|PF, then drain it.
    step("acc_zf_pf", 1'b1, 32'h0, 7'h0A, 1'b0, 3'd3, 2'b00, 1'b0, 1'b0);
    check("zf_pf_flags", 32'(status_q), 32'h0A);
    check("retired_one", retired, 32'd1);
    idle("drain_zf", 1'b1);

    // 3. Backpressure: two accepts fill the FIFO, third op stalls.
    step("bp_a", 1'b1, 32'hAAAA_0001, 7'h00, 1'b0, 3'd1, 2'b00, 1'b0, 1'b0);
    step("bp_b", 1'b1, 32'hBBBB_0002, 7'h00, 1'b1, 3'd2, 2'b00, 1'b0, 1'b0);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    step("bp_c_stall", 1'b1, 32'hCCCC_0003, 7'h00, 1'b0, 3'd4, 2'b00, 1'b0, 1'b0);
    step("bp_pop_a", 1'b1, 32'hCCCC_0003, 7'h00, 1'b0, 3'd4, 2'b00, 1'b0, 1'b1);
    check("bp_head_b", out_result, 32'hBBBB_0002);
    step("bp_pop_b_acc_c", 1'b1, 32'hCCCC_0003, 7'h00, 1'b0, 3'd4, 2'b00, 1'b0, 1'b1);
    check("bp_head_c", out_result, 32'hCCCC_0003);
    idle("bp_drain", 1'b1);

    // 4. DF handling: STD ignores in_status[DF], keep persists, CLD clears.
    step("std", 1'b1, 32'h1, 7'h00, 1'b1, 3'd0, 2'b10, 1'b0, 1'b1);
    step("df_keep", 1'b1, 32'h2, 7'h7F & ~(7'h1 << DF), 1'b0, 3'd5, 2'b00, 1'b0, 1'b1);
    check("df_persist", 32'(status_q[DF]), 32'd1);
    step("df_keep11", 1'b1, 32'h3, 7'h00, 1'b0, 3'd6, 2'b11, 1'b0, 1'b1);
    step("cld", 1'b1, 32'h4, 7'h7F, 1'b0, 3'd7, 2'b01, 1'b0, 1'b1);
    check("df_cleared", 32'(status_q[DF]), 32'd0);
    idle("df_drain", 1'b1);

    // 5. Two entries with flags 0x05, then flush with a colliding in_valid.
    step("fl_a", 1'b1, 32'h5555_0000, 7'h05, 1'b0, 3'd1, 2'b01, 1'b0, 1'b0);
    step("fl_b", 1'b1, 32'h5555_0001, 7'h05, 1'b0, 3'd2, 2'b01, 1'b0, 1'b0);
    step("flush", 1'b1, 32'hDEAD_BEEF, 7'h7A, 1'b0, 3'd3, 2'b10, 1'b1, 1'b1);
    check("flush_flags", 32'(status_q), 32'h05);
    check("flush_empty", 32'(out_valid), 32'd0);
    idle("post_flush", 1'b0);

    // 6. Retired counter wraps from all-ones to zero.
    @(negedge clk);
    force dut.retired_q = 32'hFFFF_FFFF;
    #1 release dut.retired_q;
    m_retired = 32'hFFFF_FFFF;
    step("wrap", 1'b1, 32'h77, 7'h11, 1'b0, 3'd2, 2'b00, 1'b0, 1'b1);
    check("retired_wrapped", retired, 32'h0);
    idle("wrap_drain", 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 3) != 0), $urandom, 7'($urandom), 1'($urandom),
           DEST_W'($urandom), 2'($urandom), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset mid-burst: outputs return to reset values at once.
    step("burst_a", 1'b1, 32'h1234_5678, 7'h5F, 1'b0, 3'd3, 2'b10, 1'b0, 1'b0);
    step("burst_b", 1'b1, 32'h9ABC_DEF0, 7'h3F, 1'b0, 3'd4, 2'b10, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_q.delete();
    m_flags = 7'h00;
    m_retired = 32'h0;
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_reset", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
